// File: rtl/sram_burst_ctrl.sv
// ============================================================================
// Module   : sram_burst_ctrl
// Purpose  : Moves one DATA_W-bit MEM-stage word to/from an asynchronous SRAM
//            of SRAM_DQ_W width as DATA_W/SRAM_DQ_W beats, each stretched by
//            WAIT_CYCLES wait states. ready pulses for one cycle on completion.
// Options  : define SRAM_BYTE_EN_EN to add the byte_en input (SRAM_DQ_W = 16)
//            and drive the SRAM byte lanes from it during writes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_burst_ctrl #(
   parameter int DATA_W      = 32,
   parameter int SRAM_DQ_W   = 16,
   parameter int SRAM_ADDR_W = 18,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   W_EN,
   input  logic                   R_EN,
   input  logic [31:0]            address,
   input  logic [DATA_W-1:0]      data_in,
`ifdef SRAM_BYTE_EN_EN
   input  logic [DATA_W/8-1:0]    byte_en,
`endif
   output logic [DATA_W-1:0]      data_out,
   output logic                   ready,
   inout  wire  [SRAM_DQ_W-1:0]   SRAM_DQ,
   output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
   output logic                   SRAM_UB_N,
   output logic                   SRAM_LB_N,
   output logic                   SRAM_WE_N,
   output logic                   SRAM_CE_N,
   output logic                   SRAM_OE_N
);

   localparam int BEATS   = DATA_W / SRAM_DQ_W;
   localparam int BEAT_W  = $clog2(BEATS);
   localparam int CNT_W   = (BEAT_W > 0) ? BEAT_W : 1;
   localparam int BYTE_SH = $clog2(DATA_W / 8);
   localparam int IDX_W   = SRAM_ADDR_W - BEAT_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                 state, state_nxt;
   logic [IDX_W-1:0]       word_idx;
   logic [DATA_W-1:0]      wdata;
   logic [CNT_W-1:0]       beat;
   logic [3:0]             wait_cnt;
   logic                   beat_end;
   logic                   last_beat;
   logic                   accept;
   logic                   lane_we;
   logic                   dq_drive;
   logic [SRAM_DQ_W-1:0]   beat_data;
   logic [SRAM_ADDR_W-1:0] beat_addr;
   logic                   unused_addr;

`ifdef SRAM_BYTE_EN_EN
   logic [DATA_W/8-1:0]    be;
`endif

   // Byte-offset bits and index bits beyond the SRAM size are intentionally dropped
   assign unused_addr = ^address;

   assign accept    = (state == IDLE) && (W_EN || R_EN);
   assign beat_end  = (wait_cnt == 4'(WAIT_CYCLES));
   assign last_beat = (beat == CNT_W'(BEATS - 1));
   assign beat_data = wdata[beat*SRAM_DQ_W +: SRAM_DQ_W];

`ifdef SRAM_BYTE_EN_EN
   // A beat whose two lanes are both disabled keeps its timing but never strobes WE_N
   assign lane_we = |be[2*beat +: 2];
`else
   assign lane_we = 1'b1;
`endif

   // Lowest beat sits at the lowest SRAM address of the word
   generate
      if (BEAT_W > 0) begin : g_multi_beat
         assign beat_addr = {word_idx, beat};
      end else begin : g_single_beat
         assign beat_addr = word_idx;
      end
   endgenerate

   assign SRAM_DQ = dq_drive ? beat_data : {SRAM_DQ_W{1'bz}};

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and pin decode, all derived from registered state only
   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      SRAM_CE_N = 1'b0;
      SRAM_WE_N = 1'b1;
      SRAM_OE_N = 1'b0;
      SRAM_UB_N = 1'b0;
      SRAM_LB_N = 1'b0;
      SRAM_ADDR = '0;
      dq_drive  = 1'b0;
      case (state)
         IDLE: begin
            if (W_EN)      state_nxt = WRITE;
            else if (R_EN) state_nxt = READ;
         end
         WRITE: begin
            SRAM_OE_N = 1'b1;
            SRAM_WE_N = ~lane_we;
            dq_drive  = lane_we;
            SRAM_ADDR = beat_addr;
`ifdef SRAM_BYTE_EN_EN
            SRAM_UB_N = ~be[2*beat+1];
            SRAM_LB_N = ~be[2*beat];
`endif
            if (beat_end && last_beat) state_nxt = DONE;
         end
         READ: begin
            SRAM_ADDR = beat_addr;
            if (beat_end && last_beat) state_nxt = DONE;
         end
         DONE: begin
            ready     = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Request latch, beat/wait counters and read-data capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_idx <= '0;
         wdata    <= '0;
         beat     <= '0;
         wait_cnt <= '0;
         data_out <= '0;
`ifdef SRAM_BYTE_EN_EN
         be       <= '0;
`endif
      end else if (accept) begin
         word_idx <= address[BYTE_SH +: IDX_W];
         wdata    <= data_in;
         beat     <= '0;
         wait_cnt <= '0;
`ifdef SRAM_BYTE_EN_EN
         be       <= byte_en;
`endif
      end else if (state == WRITE || state == READ) begin
         if (state == READ && beat_end)
            data_out[beat*SRAM_DQ_W +: SRAM_DQ_W] <= SRAM_DQ;
         if (beat_end) begin
            wait_cnt <= '0;
            beat     <= beat + 1'b1;
         end else begin
            wait_cnt <= wait_cnt + 4'd1;
         end
      end
   end

endmodule

`default_nettype wire
